// File: rtl/memory_op_arb.sv
// Two-lane memory-stage arbiter: captures a bundle, serialises its bus accesses over a RAM
// port and a SYS port with req/ack handshakes and an optional per-access timeout, then
// presents registered lane results to write-back with a one-cycle out_valid pulse.
`timescale 1ns/1ps
module memory_op_arb #(
  parameter int unsigned   DW      = 32,
  parameter int unsigned   AW      = 32,
  parameter int unsigned   TIMEOUT = 16,
  parameter logic [DW-1:0] FILL    = {(DW/2){2'b10}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] r1,
  input  logic [DW-1:0] r2,
  input  logic [AW-1:0] a1,
  input  logic [AW-1:0] a2,
  input  logic [3:0]    r1_op,
  input  logic [3:0]    r2_op,
  input  logic          proceed,
  output logic          ram_req,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic          ram_ack,
  input  logic [DW-1:0] ram_rdata,
  output logic          sys_req,
  output logic          sys_we,
  output logic [AW-1:0] sys_addr,
  output logic [DW-1:0] sys_wdata,
  input  logic          sys_ack,
  input  logic [DW-1:0] sys_rdata,
  output logic [DW-1:0] m1,
  output logic [DW-1:0] m2,
  output logic          out_valid,
  output logic          err
);

  typedef enum logic [1:0] {StIdle, StAcc1, StAcc2, StDone} state_t;

  // Decoded lane: m holds the final result for non-read ops and doubles as write data.
  typedef struct packed {
    logic          bus;
    logic          sys;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] m;
  } lane_t;

  localparam int unsigned CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CntMax = CW'(TIMEOUT - 1);

  function automatic lane_t f_decode(input logic [3:0] op, input logic [DW-1:0] own,
                                     input logic [DW-1:0] oth, input logic [AW-1:0] ad1,
                                     input logic [AW-1:0] ad2);
    lane_t l;
    l = '0;
    case (op)
      4'd0:  l.m = '0;
      4'd1:  l.m = own;
      4'd14: l.m = oth;
      4'd15: l.m = FILL;
      default: begin
        l.bus = 1'b1;
        l.sys = (op >= 4'd8);
        l.we  = (op inside {4'd5, 4'd6, 4'd7, 4'd11, 4'd12, 4'd13});
        l.m   = l.we ? own : '0;
        case (op)
          4'd2, 4'd5, 4'd8, 4'd11: l.addr = ad1;
          4'd3, 4'd6, 4'd9, 4'd12: l.addr = ad2;
          default:                 l.addr = oth[AW-1:0];
        endcase
      end
    endcase
    return l;
  endfunction

  state_t        r_state, w_state_d;
  logic [CW-1:0] r_cnt, w_cnt_d;
  lane_t         r_l2, w_l2_d;
  logic [DW-1:0] r_res1, w_res1_d, r_res2, w_res2_d;
  logic          r_err_acc, w_err_acc_d;
  logic [DW-1:0] r_m1, w_m1_d, r_m2, w_m2_d;
  logic          r_err, w_err_d;
  logic          r_ram_req, w_ram_req_d, r_ram_we, w_ram_we_d;
  logic [AW-1:0] r_ram_addr, w_ram_addr_d;
  logic [DW-1:0] r_ram_wdata, w_ram_wdata_d;
  logic          r_sys_req, w_sys_req_d, r_sys_we, w_sys_we_d;
  logic [AW-1:0] r_sys_addr, w_sys_addr_d;
  logic [DW-1:0] r_sys_wdata, w_sys_wdata_d;

  logic [3:0]    w_op1, w_op2;
  lane_t         w_l1, w_l2, w_iss;
  logic          w_issue, w_fin, w_ack, w_tmo, w_rd;
  logic [DW-1:0] w_rdata;

  assign w_op1   = proceed ? r1_op : 4'd0;
  assign w_op2   = proceed ? r2_op : 4'd0;
  assign w_l1    = f_decode(w_op1, r1, r2, a1, a2);
  assign w_l2    = f_decode(w_op2, r2, r1, a1, a2);
  // Only the port with an outstanding request may complete an access.
  assign w_ack   = r_ram_req ? ram_ack : (r_sys_req & sys_ack);
  assign w_rdata = r_ram_req ? ram_rdata : sys_rdata;
  assign w_rd    = ~(r_ram_req ? r_ram_we : r_sys_we);
  assign w_tmo   = (TIMEOUT != 0) && (r_cnt == CntMax);

  // Next-state, bus issue and result bookkeeping.
  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_l2_d        = r_l2;
    w_res1_d      = r_res1;
    w_res2_d      = r_res2;
    w_err_acc_d   = r_err_acc;
    w_m1_d        = r_m1;
    w_m2_d        = r_m2;
    w_err_d       = r_err;
    w_ram_req_d   = r_ram_req;
    w_ram_we_d    = r_ram_we;
    w_ram_addr_d  = r_ram_addr;
    w_ram_wdata_d = r_ram_wdata;
    w_sys_req_d   = r_sys_req;
    w_sys_we_d    = r_sys_we;
    w_sys_addr_d  = r_sys_addr;
    w_sys_wdata_d = r_sys_wdata;
    w_issue       = 1'b0;
    w_fin         = 1'b0;
    w_iss         = r_l2;

    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_l2_d      = w_l2;
          w_res1_d    = w_l1.m;
          w_res2_d    = w_l2.m;
          w_err_acc_d = (w_op1 == 4'd15) | (w_op2 == 4'd15);
          w_err_d     = 1'b0;
          w_cnt_d     = '0;
          if (w_l1.bus) begin
            w_state_d = StAcc1;
            w_issue   = 1'b1;
            w_iss     = w_l1;
          end else if (w_l2.bus) begin
            w_state_d = StAcc2;
            w_issue   = 1'b1;
            w_iss     = w_l2;
          end else begin
            w_fin = 1'b1;
          end
        end
      end
      StAcc1, StAcc2: begin
        if (w_ack || w_tmo) begin
          w_ram_req_d = 1'b0;
          w_sys_req_d = 1'b0;
          w_cnt_d     = '0;
          if (!w_ack) w_err_acc_d = 1'b1;
          if (r_state == StAcc1) begin
            if (!w_ack)    w_res1_d = FILL;
            else if (w_rd) w_res1_d = w_rdata;
          end else begin
            if (!w_ack)    w_res2_d = FILL;
            else if (w_rd) w_res2_d = w_rdata;
          end
          if ((r_state == StAcc1) && r_l2.bus) begin
            w_state_d = StAcc2;
            w_issue   = 1'b1;
            w_iss     = r_l2;
          end else begin
            w_fin = 1'b1;
          end
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase

    // Results become visible on the edge that enters DONE.
    if (w_fin) begin
      w_state_d = StDone;
      w_m1_d    = w_res1_d;
      w_m2_d    = w_res2_d;
      w_err_d   = w_err_acc_d;
    end

    if (w_issue) begin
      if (w_iss.sys) begin
        w_sys_req_d   = 1'b1;
        w_sys_we_d    = w_iss.we;
        w_sys_addr_d  = w_iss.addr;
        w_sys_wdata_d = w_iss.m;
      end else begin
        w_ram_req_d   = 1'b1;
        w_ram_we_d    = w_iss.we;
        w_ram_addr_d  = w_iss.addr;
        w_ram_wdata_d = w_iss.m;
      end
    end
  end

  // State and datapath registers; async reset drops both requests immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_l2        <= '0;
      r_res1      <= '0;
      r_res2      <= '0;
      r_err_acc   <= 1'b0;
      r_m1        <= '0;
      r_m2        <= '0;
      r_err       <= 1'b0;
      r_ram_req   <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_sys_req   <= 1'b0;
      r_sys_we    <= 1'b0;
      r_sys_addr  <= '0;
      r_sys_wdata <= '0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_l2        <= w_l2_d;
      r_res1      <= w_res1_d;
      r_res2      <= w_res2_d;
      r_err_acc   <= w_err_acc_d;
      r_m1        <= w_m1_d;
      r_m2        <= w_m2_d;
      r_err       <= w_err_d;
      r_ram_req   <= w_ram_req_d;
      r_ram_we    <= w_ram_we_d;
      r_ram_addr  <= w_ram_addr_d;
      r_ram_wdata <= w_ram_wdata_d;
      r_sys_req   <= w_sys_req_d;
      r_sys_we    <= w_sys_we_d;
      r_sys_addr  <= w_sys_addr_d;
      r_sys_wdata <= w_sys_wdata_d;
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign m1        = r_m1;
  assign m2        = r_m2;
  assign err       = r_err;
  assign ram_req   = r_ram_req;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign sys_req   = r_sys_req;
  assign sys_we    = r_sys_we;
  assign sys_addr  = r_sys_addr;
  assign sys_wdata = r_sys_wdata;

endmodule

// File: tb/tb_memory_op_arb.sv
// Bench for memory_op_arb: directed scenarios plus random bundles, checked against a
// bundle-level reference model and bus responders with scripted ack delays.
`timescale 1ns/1ps
module tb_memory_op_arb;
  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          TO    = 16;
  localparam logic [31:0] FILLV = 32'hAAAAAAAA;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] r1 = '0, r2 = '0, a1 = '0, a2 = '0;
  logic [3:0]  r1_op = '0, r2_op = '0;
  logic        proceed = 1'b0;
  logic        ram_req, ram_we, ram_ack = 1'b0;
  logic [31:0] ram_addr, ram_wdata, ram_rdata = '0;
  logic        sys_req, sys_we, sys_ack = 1'b0;
  logic [31:0] sys_addr, sys_wdata, sys_rdata = '0;
  logic [31:0] m1, m2;
  logic        out_valid, err;

  always #5 clk = ~clk;

  memory_op_arb #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .r1(r1), .r2(r2), .a1(a1), .a2(a2), .r1_op(r1_op), .r2_op(r2_op), .proceed(proceed),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .sys_req(sys_req), .sys_we(sys_we), .sys_addr(sys_addr), .sys_wdata(sys_wdata),
    .sys_ack(sys_ack), .sys_rdata(sys_rdata),
    .m1(m1), .m2(m2), .out_valid(out_valid), .err(err)
  );

  typedef struct packed {
    logic        sys;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  int n_cmp = 0;
  int n_fail = 0;
  int dly_q[$];
  acc_t obs_q[$];
  int req_cycles = 0;
  logic [31:0] ram_mem[logic [31:0]];
  logic [31:0] sys_mem[logic [31:0]];
  logic [31:0] ref_ram[logic [31:0]];
  logic [31:0] ref_sys[logic [31:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input bit sys, input logic [31:0] a);
    return sys ? (a * 32'd3 + 32'h11) : (a ^ 32'h5A5A0000);
  endfunction

  function automatic logic [31:0] env_rd(input bit sys, input logic [31:0] a);
    if (sys) return sys_mem.exists(a) ? sys_mem[a] : dflt(1'b1, a);
    return ram_mem.exists(a) ? ram_mem[a] : dflt(1'b0, a);
  endfunction

  function automatic logic [31:0] ref_rd(input bit sys, input logic [31:0] a);
    if (sys) return ref_sys.exists(a) ? ref_sys[a] : dflt(1'b1, a);
    return ref_ram.exists(a) ? ref_ram[a] : dflt(1'b0, a);
  endfunction

  // Bus responders: each new request pops the next scripted delay (0 = never ack).
  bit          rsp_busy[2];
  int          rsp_cnt[2];
  int          rsp_dly[2];
  acc_t        rsp_cur[2];
  logic        rsp_rq, rsp_wv, rsp_ack;
  logic [31:0] rsp_av, rsp_dv, rsp_rd;

  always @(negedge clk) begin
    if (!rst) begin
      rsp_busy = '{0, 0};
      ram_ack  = 1'b0;
      sys_ack  = 1'b0;
      dly_q.delete();
    end else begin
      if (ram_req || sys_req) begin
        req_cycles++;
        chk("one_req", 64'(ram_req & sys_req), 64'd0);
      end
      for (int p = 0; p < 2; p++) begin
        rsp_rq  = (p == 1) ? sys_req : ram_req;
        rsp_wv  = (p == 1) ? sys_we : ram_we;
        rsp_av  = (p == 1) ? sys_addr : ram_addr;
        rsp_dv  = (p == 1) ? sys_wdata : ram_wdata;
        rsp_ack = 1'b0;
        rsp_rd  = $urandom;
        if (rsp_rq) begin
          if (!rsp_busy[p]) begin
            rsp_busy[p] = 1'b1;
            rsp_cnt[p]  = 0;
            rsp_cur[p]  = '{sys: (p == 1), we: rsp_wv, addr: rsp_av, wdata: rsp_dv};
            obs_q.push_back(rsp_cur[p]);
            chk("dly_avail", 64'(dly_q.size() > 0), 64'd1);
            rsp_dly[p] = (dly_q.size() > 0) ? dly_q.pop_front() : 1;
          end else begin
            chk("stable_addr", 64'(rsp_av), 64'(rsp_cur[p].addr));
            chk("stable_we_wd", 64'({rsp_wv, rsp_dv}), 64'({rsp_cur[p].we, rsp_cur[p].wdata}));
          end
          rsp_cnt[p]++;
          if (rsp_dly[p] != 0 && rsp_cnt[p] == rsp_dly[p]) begin
            rsp_ack     = 1'b1;
            rsp_busy[p] = 1'b0;
            if (rsp_wv) begin
              if (p == 1) sys_mem[rsp_av] = rsp_dv;
              else        ram_mem[rsp_av] = rsp_dv;
            end else begin
              rsp_rd = env_rd(p == 1, rsp_av);
            end
          end else if (rsp_dly[p] == 0 && rsp_cnt[p] == TO) begin
            rsp_busy[p] = 1'b0;
          end
        end else begin
          rsp_busy[p] = 1'b0;
          rsp_ack     = 1'($urandom_range(0, 1));  // stray ack on an idle port
        end
        if (p == 1) begin
          sys_ack = rsp_ack; sys_rdata = rsp_rd;
        end else begin
          ram_ack = rsp_ack; ram_rdata = rsp_rd;
        end
      end
    end
  end

  task automatic run_bundle(input string tag, input logic [31:0] r1v, input logic [31:0] r2v,
                            input logic [31:0] a1v, input logic [31:0] a2v,
                            input logic [3:0] o1, input logic [3:0] o2, input bit pr,
                            input int d1, input int d2);
    logic [3:0]  op[2];
    logic [31:0] own[2], oth[2], em[2], addr;
    int          dl[2];
    int          lat, reqc, lat_o, w, idx;
    bit          eerr, done, sys, wr;
    acc_t        eq[$];
    op[0] = pr ? o1 : 4'd0;  op[1] = pr ? o2 : 4'd0;
    own[0] = r1v; oth[0] = r2v; own[1] = r2v; oth[1] = r1v;
    dl[0] = d1; dl[1] = d2;
    lat = 1; reqc = 0; eerr = 1'b0;
    for (int l = 0; l < 2; l++) begin
      if (op[l] == 4'd0)       em[l] = '0;
      else if (op[l] == 4'd1)  em[l] = own[l];
      else if (op[l] == 4'd14) em[l] = oth[l];
      else if (op[l] == 4'd15) begin em[l] = FILLV; eerr = 1'b1; end
      else begin
        idx  = int'(op[l]) - 2;
        sys  = (idx >= 6);
        wr   = ((idx % 6) >= 3);
        addr = (idx % 3 == 0) ? a1v : (idx % 3 == 1) ? a2v : oth[l];
        eq.push_back('{sys: sys, we: wr, addr: addr, wdata: wr ? own[l] : 32'd0});
        dly_q.push_back(dl[l]);
        if (dl[l] == 0) begin
          em[l] = FILLV; eerr = 1'b1; lat += TO; reqc += TO;
        end else begin
          lat += dl[l]; reqc += dl[l];
          if (wr) begin
            em[l] = own[l];
            if (sys) ref_sys[addr] = own[l];
            else     ref_ram[addr] = own[l];
          end else begin
            em[l] = ref_rd(sys, addr);
          end
        end
      end
    end
    obs_q.delete();
    req_cycles = 0;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    r1 = r1v; r2 = r2v; a1 = a1v; a2 = a2v; r1_op = o1; r2_op = o2; proceed = pr;
    in_valid = 1'b1;
    @(posedge clk);
    lat_o = 1; done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (k == 0) begin
        in_valid = 1'b0; r1 = $urandom; r2 = $urandom; a1 = $urandom; a2 = $urandom;
        r1_op = 4'($urandom); r2_op = 4'($urandom); proceed = 1'($urandom);
      end
      if (out_valid) done = 1'b1;
      else begin @(posedge clk); lat_o++; end
    end
    chk({tag, "_latency"}, 64'(lat_o), 64'(lat));
    chk({tag, "_m1"}, 64'(m1), 64'(em[0]));
    chk({tag, "_m2"}, 64'(m2), 64'(em[1]));
    chk({tag, "_err"}, 64'(err), 64'(eerr));
    chk({tag, "_req_cycles"}, 64'(req_cycles), 64'(reqc));
    chk({tag, "_n_acc"}, 64'(obs_q.size()), 64'(eq.size()));
    for (int i = 0; i < eq.size() && i < obs_q.size(); i++) begin
      chk({tag, "_acc_kind"}, 64'({obs_q[i].sys, obs_q[i].we}), 64'({eq[i].sys, eq[i].we}));
      chk({tag, "_acc_addr"}, 64'(obs_q[i].addr), 64'(eq[i].addr));
      if (eq[i].we) chk({tag, "_acc_wdata"}, 64'(obs_q[i].wdata), 64'(eq[i].wdata));
    end
    chk({tag, "_dly_used"}, 64'(dly_q.size()), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_pulse_end"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'h10 + 32'(4 * $urandom_range(0, 3));
  endfunction

  initial begin
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_reqs", 64'({ram_req, sys_req}), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_m", 64'({m1, m2}), 64'd0);
    chk("rst_err_addr", 64'({err, ram_addr}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_bundle("t1", 32'd5, 32'd9, 32'h0, 32'h0, 4'd1, 4'd14, 1'b1, 1, 1);
    run_bundle("t2", 32'h1234, 32'h5678, 32'h10, 32'h14, 4'd5, 4'd2, 1'b0, 1, 1);
    run_bundle("t3", 32'hDEAD, 32'h0, 32'h10, 32'h10, 4'd5, 4'd2, 1'b1, 2, 2);
    run_bundle("t4", 32'h0, 32'h0, 32'h40, 32'h0, 4'd8, 4'd0, 1'b1, 0, 1);
    sys_mem[32'h20] = 32'd7;
    ref_sys[32'h20] = 32'd7;
    run_bundle("t5", 32'h20, 32'h3, 32'h0, 32'h0, 4'd15, 4'd10, 1'b1, 1, 1);

    // Reset while lane 2 waits on RAM in ACC2.
    obs_q.delete();
    dly_q.push_back(1);
    dly_q.push_back(0);
    r1 = 32'h1; r2 = 32'h2; a1 = 32'h18; a2 = 32'h1c; r1_op = 4'd2; r2_op = 4'd3;
    proceed = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("t6_pre_req", 64'(ram_req), 64'd1);
    rst = 1'b0;
    #1;
    chk("t6_async_req", 64'({ram_req, sys_req}), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd1);
    chk("t6_outs", 64'({out_valid, err}), 64'd0);
    chk("t6_m", 64'({m1, m2}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_ready_rel", 64'(in_ready), 64'd1);
    run_bundle("t6_next", 32'h77, 32'h88, 32'h14, 32'h18, 4'd6, 4'd9, 1'b1, 3, 2);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom_range(0, 1) ? rnd_addr() : $urandom;
      rb = $urandom_range(0, 1) ? rnd_addr() : $urandom;
      run_bundle("rnd", ra, rb, rnd_addr(), rnd_addr(), 4'($urandom), 4'($urandom),
                 ($urandom_range(0, 9) != 0), $urandom_range(0, 4), $urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion expected finish within 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
